// File: rtl/bench_1_l3_cnt_ext.sv
// Layer-3 counter-extension stage of bench_1.
// Registers the layer-2 carry/full crossings, extends the three counter chains with
// W-bit upper segments, and provides sticky wrap flags, an all-full status and a
// threshold interrupt with an acknowledge handshake.
module bench_1_l3_cnt_ext #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk1,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_cin_a,
   input  logic         i_cin_b,
   input  logic         i_cin_c,
   input  logic         i_full_a_n,
   input  logic         i_nfull_bc,
   input  logic [2:0]   i_clr,
   input  logic [W-1:0] i_thresh,
   input  logic         i_ack,
   output logic [W-1:0] o_cnt_a,
   output logic [W-1:0] o_cnt_b,
   output logic [W-1:0] o_cnt_c,
   output logic [2:0]   o_ovf,
   output logic         o_irq,
   output logic         o_all_full,
   output logic [1:0]   o_state
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StHit   = 2'd2,
      StWait  = 2'd3
   } state_e;

   logic [2:0]   r_cin_q;
   logic         r_full_a_n_q;
   logic         r_nfull_bc_q;
   logic [W-1:0] r_cnt [3];
   logic [2:0]   r_ovf;
   logic         r_all_full;
   logic         r_irq;
   state_e       r_state;

   logic         w_cnt_all_ones;

   // Capture the TSV landings every cycle; only the registered copies are used downstream.
   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cin_q      <= 3'b000;
         r_full_a_n_q <= 1'b0;
         r_nfull_bc_q <= 1'b0;
      end else begin
         r_cin_q      <= {i_cin_c, i_cin_b, i_cin_a};
         r_full_a_n_q <= i_full_a_n;
         r_nfull_bc_q <= i_nfull_bc;
      end
   end

   // Upper segments: clear beats increment, and the wrap sets the sticky flag.
   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (i_clr[i]) begin
               r_cnt[i] <= '0;
               r_ovf[i] <= 1'b0;
            end else if (i_en && r_cin_q[i]) begin
               r_cnt[i] <= r_cnt[i] + W'(1);
               if (&r_cnt[i]) begin
                  r_ovf[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Whole chain full: layer-2 flags (already registered) plus every upper segment saturated.
   assign w_cnt_all_ones = (&r_cnt[0]) && (&r_cnt[1]) && (&r_cnt[2]);

   // Registered all-full status.
   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_all_full <= 1'b0;
      end else begin
         r_all_full <= !r_full_a_n_q && !r_nfull_bc_q && w_cnt_all_ones;
      end
   end

   // Threshold FSM; irq is registered so it is high exactly while in StHit.
   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_irq   <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_en) begin
                  r_state <= StArmed;
               end
            end
            StArmed: begin
               // Losing enable disarms even on a matching cycle.
               if (!i_en) begin
                  r_state <= StIdle;
               end else if (r_cnt[0] == i_thresh) begin
                  r_state <= StHit;
                  r_irq   <= 1'b1;
               end
            end
            StHit: begin
               r_state <= StWait;
            end
            StWait: begin
               if (i_ack) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_cnt_a    = r_cnt[0];
   assign o_cnt_b    = r_cnt[1];
   assign o_cnt_c    = r_cnt[2];
   assign o_ovf      = r_ovf;
   assign o_irq      = r_irq;
   assign o_all_full = r_all_full;
   assign o_state    = r_state;

endmodule

// File: tb/tb_bench_1_l3_cnt_ext.sv
// Self-checking bench for bench_1_l3_cnt_ext: vector table for segment counting plus
// hand-written sequences for reset, wrap, interrupt handshake, abort and all-full.
module tb_bench_1_l3_cnt_ext;

   localparam int unsigned W = 4;

   logic         clk1;
   logic         rst_n;
   logic         en;
   logic         cin_a;
   logic         cin_b;
   logic         cin_c;
   logic         full_a_n;
   logic         nfull_bc;
   logic [2:0]   clr;
   logic [W-1:0] thresh;
   logic         ack;
   logic [W-1:0] cnt_a;
   logic [W-1:0] cnt_b;
   logic [W-1:0] cnt_c;
   logic [2:0]   ovf;
   logic         irq;
   logic         all_full;
   logic [1:0]   state;

   bench_1_l3_cnt_ext #(.W(W)) dut (
      .i_clk1     (clk1),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_cin_a    (cin_a),
      .i_cin_b    (cin_b),
      .i_cin_c    (cin_c),
      .i_full_a_n (full_a_n),
      .i_nfull_bc (nfull_bc),
      .i_clr      (clr),
      .i_thresh   (thresh),
      .i_ack      (ack),
      .o_cnt_a    (cnt_a),
      .o_cnt_b    (cnt_b),
      .o_cnt_c    (cnt_c),
      .o_ovf      (ovf),
      .o_irq      (irq),
      .o_all_full (all_full),
      .o_state    (state)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   localparam int SigCntA = 0;
   localparam int SigCntB = 1;
   localparam int SigCntC = 2;
   localparam int SigOvf  = 3;
   localparam int SigIrq  = 4;
   localparam int SigAll  = 5;
   localparam int SigSt   = 6;

   typedef struct {
      int         sig;
      string      name;
      logic [7:0] exp;
   } sb_t;

   sb_t sb_q[$];

   typedef struct {
      logic       en;
      logic [2:0] cin;   // {c, b, a}
      logic [2:0] clr;
      logic [3:0] ea;
      logic [3:0] eb;
      logic [3:0] ec;
      logic [2:0] eovf;
   } vec_t;

   vec_t vecs[10];

   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [7:0] get_sig(input int sig);
      case (sig)
         SigCntA: return {4'b0, cnt_a};
         SigCntB: return {4'b0, cnt_b};
         SigCntC: return {4'b0, cnt_c};
         SigOvf:  return {5'b0, ovf};
         SigIrq:  return {7'b0, irq};
         SigAll:  return {7'b0, all_full};
         SigSt:   return {6'b0, state};
         default: return 8'hff;
      endcase
   endfunction

   task automatic expect_sig(input int sig, input string name, input logic [7:0] exp);
      sb_t e;
      e.sig  = sig;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   // Pop every pending expectation and compare against the DUT outputs now.
   task automatic drain();
      sb_t        e;
      logic [7:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = get_sig(e.sig);
         n_checks++;
         if (act !== e.exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   task automatic set_cin(input logic [2:0] c);
      cin_a = c[0];
      cin_b = c[1];
      cin_c = c[2];
   endtask

   task automatic defaults();
      en       = 1'b0;
      set_cin(3'b000);
      full_a_n = 1'b1;
      nfull_bc = 1'b1;
      clr      = 3'b000;
      thresh   = 4'd15;
      ack      = 1'b0;
   endtask

   task automatic do_reset();
      defaults();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{en: 1'b1, cin: 3'b000, clr: 3'b000, ea: 0, eb: 0, ec: 0, eovf: 3'b000};
      vecs[1] = '{en: 1'b1, cin: 3'b010, clr: 3'b000, ea: 0, eb: 0, ec: 0, eovf: 3'b000};
      vecs[2] = '{en: 1'b1, cin: 3'b000, clr: 3'b000, ea: 0, eb: 1, ec: 0, eovf: 3'b000};
      vecs[3] = '{en: 1'b1, cin: 3'b000, clr: 3'b000, ea: 0, eb: 1, ec: 0, eovf: 3'b000};
      vecs[4] = '{en: 1'b1, cin: 3'b101, clr: 3'b000, ea: 0, eb: 1, ec: 0, eovf: 3'b000};
      vecs[5] = '{en: 1'b0, cin: 3'b101, clr: 3'b000, ea: 0, eb: 1, ec: 0, eovf: 3'b000};
      vecs[6] = '{en: 1'b1, cin: 3'b000, clr: 3'b000, ea: 1, eb: 1, ec: 1, eovf: 3'b000};
      vecs[7] = '{en: 1'b1, cin: 3'b111, clr: 3'b010, ea: 1, eb: 0, ec: 1, eovf: 3'b000};
      vecs[8] = '{en: 1'b1, cin: 3'b000, clr: 3'b001, ea: 0, eb: 1, ec: 2, eovf: 3'b000};
      vecs[9] = '{en: 1'b1, cin: 3'b000, clr: 3'b000, ea: 0, eb: 1, ec: 2, eovf: 3'b000};

      defaults();
      rst_n = 1'b0;

      // Reset with random inputs: everything held at zero.
      for (int i = 0; i < 4; i++) begin
         en       = 1'($urandom_range(1));
         set_cin(3'($urandom_range(7)));
         clr      = 3'($urandom_range(7));
         ack      = 1'($urandom_range(1));
         full_a_n = 1'($urandom_range(1));
         nfull_bc = 1'($urandom_range(1));
         thresh   = 4'($urandom_range(15));
         tick(1);
      end
      expect_sig(SigCntA, "rst_cnt_a", 8'd0);
      expect_sig(SigCntB, "rst_cnt_b", 8'd0);
      expect_sig(SigCntC, "rst_cnt_c", 8'd0);
      expect_sig(SigOvf,  "rst_ovf",   8'd0);
      expect_sig(SigIrq,  "rst_irq",   8'd0);
      expect_sig(SigAll,  "rst_all",   8'd0);
      expect_sig(SigSt,   "rst_state", 8'd0);
      drain();
      defaults();
      rst_n = 1'b1;
      tick(1);
      expect_sig(SigSt, "idle_after_rst", 8'd0);
      drain();
      en = 1'b1;
      expect_sig(SigSt, "armed_after_en", 8'd1);
      tick(1);
      drain();

      // Table: latency, enable gating, per-segment clear.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         en  = vecs[i].en;
         set_cin(vecs[i].cin);
         clr = vecs[i].clr;
         expect_sig(SigCntA, $sformatf("vec%0d_cnt_a", i), {4'b0, vecs[i].ea});
         expect_sig(SigCntB, $sformatf("vec%0d_cnt_b", i), {4'b0, vecs[i].eb});
         expect_sig(SigCntC, $sformatf("vec%0d_cnt_c", i), {4'b0, vecs[i].ec});
         expect_sig(SigOvf,  $sformatf("vec%0d_ovf", i),   {5'b0, vecs[i].eovf});
         tick(1);
         drain();
      end

      // Wrap of segment C, then clear beats a pending carry.
      do_reset();
      en = 1'b1;
      set_cin(3'b100);
      tick(16);
      expect_sig(SigCntC, "wrap_pre_cnt", 8'd15);
      expect_sig(SigOvf,  "wrap_pre_ovf", 8'd0);
      drain();
      set_cin(3'b000);
      tick(1);
      expect_sig(SigCntC, "wrap_cnt", 8'd0);
      expect_sig(SigOvf,  "wrap_ovf", 8'b100);
      drain();
      set_cin(3'b100);
      tick(1);
      expect_sig(SigOvf, "ovf_sticky", 8'b100);
      drain();
      set_cin(3'b000);
      clr = 3'b100;
      tick(1);
      expect_sig(SigCntC, "clr_cnt", 8'd0);
      expect_sig(SigOvf,  "clr_ovf", 8'd0);
      drain();
      clr = 3'b000;
      tick(1);
      expect_sig(SigCntC, "clr_no_inc", 8'd0);
      drain();

      // Interrupt handshake at thresh=3.
      do_reset();
      thresh = 4'd3;
      en     = 1'b1;
      tick(1);
      set_cin(3'b001);
      tick(3);
      expect_sig(SigCntA, "irq_cnt2", 8'd2);
      expect_sig(SigSt,   "irq_armed", 8'd1);
      drain();
      set_cin(3'b000);
      tick(1);
      expect_sig(SigCntA, "irq_cnt3", 8'd3);
      expect_sig(SigIrq,  "irq_not_yet", 8'd0);
      drain();
      tick(1);
      expect_sig(SigSt,  "irq_hit", 8'd2);
      expect_sig(SigIrq, "irq_high", 8'd1);
      drain();
      tick(1);
      expect_sig(SigSt,  "irq_wait", 8'd3);
      expect_sig(SigIrq, "irq_pulse_end", 8'd0);
      drain();
      tick(5);
      expect_sig(SigSt, "wait_hold", 8'd3);
      drain();
      ack = 1'b1;
      tick(1);
      expect_sig(SigSt, "ack_idle", 8'd0);
      drain();
      ack = 1'b0;
      tick(1);
      expect_sig(SigSt, "rearm", 8'd1);
      drain();

      // Abort: enable drops on the matching cycle.
      do_reset();
      thresh = 4'd1;
      en     = 1'b1;
      tick(1);
      set_cin(3'b001);
      tick(1);
      set_cin(3'b000);
      tick(1);
      expect_sig(SigCntA, "abort_match", 8'd1);
      expect_sig(SigSt,   "abort_armed", 8'd1);
      drain();
      en = 1'b0;
      tick(1);
      expect_sig(SigSt,  "abort_idle", 8'd0);
      expect_sig(SigIrq, "abort_no_irq", 8'd0);
      drain();
      tick(1);
      expect_sig(SigIrq, "abort_no_irq2", 8'd0);
      drain();
      en = 1'b1;
      tick(2);
      expect_sig(SigSt, "abort_hit", 8'd2);
      drain();
      tick(1);
      en = 1'b0;
      tick(3);
      expect_sig(SigSt, "wait_en_low", 8'd3);
      drain();
      ack = 1'b1;
      tick(1);
      expect_sig(SigSt, "wait_ack_en_low", 8'd0);
      drain();

      // Reset mid-handshake returns to idle without a clock edge.
      en = 1'b1;
      ack = 1'b0;
      tick(3);
      expect_sig(SigSt, "pre_async_wait", 8'd3);
      drain();
      ack   = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      expect_sig(SigSt, "async_rst_state", 8'd0);
      drain();
      tick(1);

      // All-full: saturate all counts, then drop the layer-2 flags.
      do_reset();
      en = 1'b1;
      set_cin(3'b111);
      tick(15);
      set_cin(3'b000);
      tick(1);
      expect_sig(SigCntA, "full_cnt_a", 8'd15);
      expect_sig(SigCntB, "full_cnt_b", 8'd15);
      expect_sig(SigCntC, "full_cnt_c", 8'd15);
      expect_sig(SigAll,  "full_flags_high", 8'd0);
      drain();
      full_a_n = 1'b0;
      nfull_bc = 1'b0;
      tick(1);
      expect_sig(SigAll, "full_lat1", 8'd0);
      drain();
      tick(1);
      expect_sig(SigAll, "full_set", 8'd1);
      drain();
      nfull_bc = 1'b1;
      tick(1);
      expect_sig(SigAll, "full_hold", 8'd1);
      drain();
      tick(1);
      expect_sig(SigAll, "full_drop", 8'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bench_1_l3_cnt_ext.md
# bench_1_l3_cnt_ext

Layer-3 counter-extension stage of bench_1. It sits directly downstream of bench_1_L2 and receives that layer's segment carry-outs and full-detect flags through TSV landings. It registers each crossing, then extends the three layer-2 counter chains with upper segments. It also produces sticky overflow flags, a threshold interrupt with an acknowledge handshake, and a combined all-full status.

## Interface
- W, 4, width of each upper counter segment and of `thresh`
- clk1  in  1  sole clock; all flops rising-edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global count enable; gates increments and arms the FSM
- cin_a  in  1  carry-out of layer-2 segment A (5–8 chain)
- cin_b  in  1  carry-out of layer-2 segment B (16–23 chain)
- cin_c  in  1  carry-out of layer-2 segment C (29–32 chain)
- full_a_n  in  1  low when layer-2 segment A is all ones
- nfull_bc  in  1  high when any layer-2 B/C nibble is not all ones
- clr  in  3  synchronous clear per segment; bit0 = A, bit1 = B, bit2 = C
- thresh  in  W  match value for `cnt_a`
- ack  in  1  interrupt acknowledge
- cnt_a, cnt_b, cnt_c  out  W  upper-segment counts
- ovf  out  3  sticky wrap flags; same bit order as `clr`
- irq  out  1  threshold-hit pulse
- all_full  out  1  registered whole-chain-full flag
- state  out  2  FSM state (IDLE=0, ARMED=1, HIT=2, WAIT=3)

## Operation
- Capture stage: `cin_a/b/c`, `full_a_n` and `nfull_bc` are registered into `*_q` every cycle, regardless of `en`. Nothing downstream uses the raw inputs.
- Segment X (A/B/C), evaluated in priority order:
  - `clr[X]` = 1: `cnt_X` ← 0 and `ovf[X]` ← 0.
  - Otherwise, if `en` and `cin_X_q`: `cnt_X` ← `cnt_X` + 1, modulo 2^W.
  - If that increment takes the count from all ones to 0, `ovf[X]` ← 1 and holds until cleared.
  - Otherwise the segment holds.
- Clear always wins over a simultaneous carry and over a simultaneous overflow set.
- `all_full` ← the registered AND of: `!full_a_n_q`, `!nfull_bc_q`, and every `cnt_X` == all ones.
- FSM:
  - IDLE → ARMED when `en` = 1.
  - ARMED → HIT when `cnt_a` == `thresh`, comparing current register values.
  - ARMED → IDLE when `en` = 0. This takes priority over a match.
  - HIT → WAIT unconditionally after one cycle.
  - WAIT → IDLE when `ack` = 1. `ack` in any other state is ignored.
  - `en` dropping in HIT or WAIT does not abort the handshake.
- `irq` = 1 exactly while `state` == HIT. It is registered, so it is a one-cycle pulse.
- From IDLE with `cnt_a` == `thresh` already true, the FSM still passes through ARMED first: IDLE → ARMED → HIT.

## Timing
- Reset (rst_n low, asynchronous): all counts 0, `ovf` = 0, `irq` = 0, `all_full` = 0, `state` = IDLE, all capture regs 0.
- Carry latency, for a carry high at edge k:
  - edge k: captured into `cin_X_q`.
  - edge k+1: count increments, visible after k+1, i.e. 2 cycles input-to-output.
- `ovf` sets on the same edge as the wrapping increment.
- `all_full` has 2 cycles of latency from the layer-2 flags and 1 cycle from the counts.
- Threshold latency: `cnt_a` reaching `thresh` at edge j gives HIT/`irq` after edge j+1 and WAIT after j+2.
- A carry held high continuously increments every cycle. There is no edge detection.
- Reset asserted mid-handshake returns to IDLE immediately. A pending `ack` is discarded.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs 0, `state` = 0. Release, then set en=1 → `state` = 1 after the next edge.
- Latency: en=1, single-cycle `cin_b` pulse at edge 10 → `cnt_b` = 1 after edge 11. `cnt_a` and `cnt_c` stay 0.
- Wrap: W=4, en=1, `cin_c` held for 16 cycles → `cnt_c` = 0 and `ovf[2]` = 1. Then clr[2] together with `cin_c_q`=1 → `cnt_c` = 0, `ovf[2]` = 0, no increment.
- Interrupt: thresh=3, en=1, three `cin_a` pulses → one-cycle `irq`, then `state` = 3. Hold `ack` low 5 cycles → stays 3. Pulse `ack` → `state` = 0, then 1.
- Abort: ARMED with en dropped on the same cycle `cnt_a` matches → IDLE, no `irq`. Drop en while in WAIT → remains WAIT until `ack`.
- All-full: drive `cin_*` until all counts = 15, then full_a_n=0 and nfull_bc=0 → `all_full` = 1 two cycles later. Raising `nfull_bc` → 0 two cycles later.
